// File: rtl/dsm_dac_order_n_if.sv
// Signal bundle between the sample-rate data path and the delta-sigma modulator.
// Strobe semantics: i_data is taken only on a cycle with i_sample=1 (no backpressure);
// o_valid pulses exactly one cycle later, alongside the new o_dac_out bit.
interface dsm_dac_order_n_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  i_sample;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ovl_clr;
  logic                  o_dac_out;
  logic                  o_valid;
  logic                  o_overload;

  modport master (
    output i_sample, i_data, i_ovl_clr,
    input  o_dac_out, o_valid, o_overload
  );

  modport slave (
    input  i_sample, i_data, i_ovl_clr,
    output o_dac_out, o_valid, o_overload
  );
endinterface

// File: rtl/dsm_dac_order_n.sv
// Single-bit delta-sigma DAC modulator, first or second order (MOD1/MOD2),
// with saturating integrators and a sticky overload flag.
module dsm_dac_order_n #(
  parameter int DATA_WIDTH   = 4,
  parameter int ORDER        = 2,
  parameter int ACC_WIDTH    = DATA_WIDTH + 4,
  parameter int FEEDBACK_MAG = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dsm_dac_order_n_if.slave  bus
);

  localparam int MIN_EW = DATA_WIDTH + ORDER + 2;
  localparam int EW     = (ACC_WIDTH > MIN_EW) ? ACC_WIDTH : MIN_EW;
  localparam int SW     = EW + 2;

  localparam logic signed [SW-1:0] FB      = SW'(FEEDBACK_MAG << (DATA_WIDTH - 1));
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(EW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(EW-1){1'b0}}};

  if (ORDER != 1 && ORDER != 2) begin : g_order_check
    $error("dsm_dac_order_n: ORDER must be 1 or 2");
  end

  logic signed [EW-1:0] int1_q, int2_q;
  logic                 dac_q, valid_q, ovl_q;

  logic signed [SW-1:0] d, x_ext, sum1, sum2;
  logic signed [EW-1:0] int1_nxt, int2_nxt;
  logic                 ovf1, ovf2, event_ovl, bit_nxt;

  function automatic logic signed [EW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[EW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[EW-1:0];
    else                  sat = v[EW-1:0];
  endfunction

  always_comb begin
    d        = dac_q ? FB : -FB;
    x_ext    = {{(SW-DATA_WIDTH){bus.i_data[DATA_WIDTH-1]}}, bus.i_data};
    sum1     = {{2{int1_q[EW-1]}}, int1_q} + x_ext - d;
    int1_nxt = sat(sum1);
    ovf1     = (sum1 > SAT_MAX) || (sum1 < SAT_MIN);
    // Second stage integrates the already-saturated first-stage result.
    sum2     = {{2{int2_q[EW-1]}}, int2_q} + {{2{int1_nxt[EW-1]}}, int1_nxt} - d;
    int2_nxt = sat(sum2);
    ovf2     = (sum2 > SAT_MAX) || (sum2 < SAT_MIN);
    if (ORDER == 2) begin
      bit_nxt   = ~int2_nxt[EW-1];
      event_ovl = ovf1 || ovf2;
    end else begin
      bit_nxt   = ~int1_nxt[EW-1];
      event_ovl = ovf1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      int1_q  <= '0;
      int2_q  <= '0;
      dac_q   <= 1'b1;
      valid_q <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      valid_q <= bus.i_sample;
      if (bus.i_sample) begin
        int1_q <= int1_nxt;
        if (ORDER == 2) int2_q <= int2_nxt;
        dac_q  <= bit_nxt;
      end
      // A new overload event beats a simultaneous clear.
      if (bus.i_sample && event_ovl) ovl_q <= 1'b1;
      else if (bus.i_ovl_clr)        ovl_q <= 1'b0;
    end
  end

  assign bus.o_dac_out  = dac_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_overload = ovl_q;

endmodule

// File: tb/tb_dsm_dac_order_n.sv
// Directed bench for dsm_dac_order_n: one ORDER=1 and one ORDER=2 instance,
// hand-computed bit/integrator sequences, overload set/clear and gapped strobes.
module tb_dsm_dac_order_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dsm_dac_order_n_if #(.DATA_WIDTH(4)) bus1 ();
  dsm_dac_order_n_if #(.DATA_WIDTH(4)) bus2 ();

  dsm_dac_order_n #(.DATA_WIDTH(4), .ORDER(1), .ACC_WIDTH(8), .FEEDBACK_MAG(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  dsm_dac_order_n #(.DATA_WIDTH(4), .ORDER(2), .ACC_WIDTH(8), .FEEDBACK_MAG(1)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2.slave)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic s, input logic [3:0] x, input logic clr);
    bus1.i_sample  = s;
    bus1.i_data    = x;
    bus1.i_ovl_clr = clr;
    @(posedge clk);
    #1;
    bus1.i_sample  = 1'b0;
    bus1.i_ovl_clr = 1'b0;
  endtask

  task automatic step2(input logic s, input logic [3:0] x, input logic clr);
    bus2.i_sample  = s;
    bus2.i_data    = x;
    bus2.i_ovl_clr = clr;
    @(posedge clk);
    #1;
    bus2.i_sample  = 1'b0;
    bus2.i_ovl_clr = 1'b0;
  endtask

  // Two reset cycles with strobes toggling on both buses.
  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus1.i_sample = (c == 0);
      bus2.i_sample = (c == 0);
      bus1.i_data   = 4'sd5;
      bus2.i_data   = -4'sd7;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus1.i_sample = 1'b0;
    bus2.i_sample = 1'b0;
    bus1.i_data   = '0;
    bus2.i_data   = '0;
  endtask

  initial begin
    int ones;
    int exp_i2[4];
    logic exp_b;
    bus1.i_sample = 1'b0; bus1.i_data = '0; bus1.i_ovl_clr = 1'b0;
    bus2.i_sample = 1'b0; bus2.i_data = '0; bus2.i_ovl_clr = 1'b0;
    exp_i2 = '{-16, -8, 8, 0};

    // Reset state
    do_reset();
    check("rst_dac1",  bus1.o_dac_out, 1);
    check("rst_valid1", bus1.o_valid, 0);
    check("rst_ovl1",  bus1.o_overload, 0);
    check("rst_int1a", u_dut1.int1_q, 0);
    check("rst_dac2",  bus2.o_dac_out, 1);
    check("rst_valid2", bus2.o_valid, 0);
    check("rst_ovl2",  bus2.o_overload, 0);
    check("rst_int1b", u_dut2.int1_q, 0);
    check("rst_int2b", u_dut2.int2_q, 0);

    // ORDER=1, x=0: bits 0,1,0,1 and int1 -8,0,-8,0
    for (int i = 0; i < 4; i++) begin
      step1(1'b1, 4'd0, 1'b0);
      check("o1_x0_bit", bus1.o_dac_out, (i % 2 == 0) ? 0 : 1);
      check("o1_x0_int", u_dut1.int1_q, (i % 2 == 0) ? -8 : 0);
      check("o1_x0_vld", bus1.o_valid, 1);
    end
    step1(1'b0, 4'd0, 1'b0);
    check("o1_vld_low", bus1.o_valid, 0);

    // ORDER=1, x=+4: pattern 0,1,1,1, 12 ones in 16
    do_reset();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step1(1'b1, 4'd4, 1'b0);
      exp_b = (i % 4 != 0);
      check("o1_x4_bit", bus1.o_dac_out, exp_b);
      ones += int'(bus1.o_dac_out);
    end
    check("o1_x4_ones", ones, 12);

    // ORDER=2, x=0: bits 0,0,1,1 and int2 -16,-8,8,0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step2(1'b1, 4'd0, 1'b0);
      check("o2_x0_bit", bus2.o_dac_out, (i % 4 < 2) ? 0 : 1);
      check("o2_x0_int2", u_dut2.int2_q, exp_i2[i % 4]);
    end

    // ORDER=2, x=-8: int2 walks down to -128, overload on sample 15
    do_reset();
    for (int n = 1; n <= 14; n++) begin
      step2(1'b1, 4'b1000, 1'b0);
      check("ovl_int2", u_dut2.int2_q, -16 - 8 * n);
      check("ovl_flag_lo", bus2.o_overload, 0);
      check("ovl_bit", bus2.o_dac_out, 0);
    end
    step2(1'b1, 4'b1000, 1'b0);
    check("ovl_int2_clamp", u_dut2.int2_q, -128);
    check("ovl_flag_set", bus2.o_overload, 1);
    check("ovl_bit15", bus2.o_dac_out, 0);
    step2(1'b1, 4'b1000, 1'b1);
    check("ovl_set_wins", bus2.o_overload, 1);
    check("ovl_int1_hold", u_dut2.int1_q, -16);
    step2(1'b1, 4'd0, 1'b1);
    check("ovl_cleared", bus2.o_overload, 0);
    check("ovl_x0_int1", u_dut2.int1_q, -8);
    check("ovl_x0_int2", u_dut2.int2_q, -128);

    // Gapped strobe (1 in 4), ORDER=2, x=0: same 0,0,1,1 sequence
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step2(1'b1, 4'd0, 1'b0);
      exp_b = (i % 4 >= 2);
      check("gap_bit", bus2.o_dac_out, exp_b);
      check("gap_vld", bus2.o_valid, 1);
      for (int k = 0; k < 3; k++) begin
        step2(1'b0, 4'd0, 1'b0);
        check("gap_hold", bus2.o_dac_out, exp_b);
        check("gap_vld_lo", bus2.o_valid, 0);
      end
      check("gap_int2", u_dut2.int2_q, exp_i2[i % 4]);
    end

    // Reset mid-sequence restarts the pattern
    step2(1'b1, 4'd0, 1'b0);
    step2(1'b1, 4'd0, 1'b0);
    rst = 1'b1;
    step2(1'b1, 4'd0, 1'b0);
    rst = 1'b0;
    check("midrst_dac", bus2.o_dac_out, 1);
    check("midrst_int2", u_dut2.int2_q, 0);
    for (int i = 0; i < 4; i++) begin
      step2(1'b1, 4'd0, 1'b0);
      check("midrst_bit", bus2.o_dac_out, (i < 2) ? 0 : 1);
      step2(1'b0, 4'd0, 1'b0);
      step2(1'b0, 4'd0, 1'b0);
      step2(1'b0, 4'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsm_dac_order_n.md
Name: dsm_dac_order_n

Overview:
Parametrised 1st/2nd-order single-bit delta-sigma DAC modulator. It succeeds the first-order DAC and adds a selectable order (MOD1/MOD2 topology), integrator saturation, a sticky overload flag and an output-valid strobe. It sits between the sample-rate data path (signed PCM words gated by a sample strobe) and the 1-bit output pin / reconstruction filter.

Parameters:
DATA_WIDTH, 4, width of signed input word i_data.
ORDER, 2, modulator order; legal values 1 or 2, any other value is a static elaboration error.
ACC_WIDTH, DATA_WIDTH+4, requested integrator width. Effective width EW = max(ACC_WIDTH, DATA_WIDTH+ORDER+2).
FEEDBACK_MAG, 1, feedback scale. Feedback magnitude FB = FEEDBACK_MAG << (DATA_WIDTH-1).

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous reset, active-high
i_sample  input  1  modulator update strobe, one cycle per output bit
i_data  input  DATA_WIDTH  signed input sample, consumed on i_sample cycle
i_ovl_clr  input  1  clears o_overload
o_dac_out  output  1  registered 1-bit modulator output
o_valid  output  1  one-cycle pulse, cycle after each i_sample
o_overload  output  1  sticky flag: an integrator saturated

Behaviour:
- State: int1 (and int2 when ORDER=2), signed EW bits each; o_dac_out register v.
- Reset (i_rst=1 at clock edge): int1=int2=0, o_dac_out=1 (Q(0)=1), o_valid=0, o_overload=0. Reset overrides every other input, including mid-operation.
- Feedback: d = v ? +FB : -FB, sign-extended to EW+2.
- i_sample=1: all arithmetic is in EW+2 bits, then saturated to [-2^(EW-1), 2^(EW-1)-1].
  - ORDER=1: int1' = sat(int1 + x - d); o_dac_out <= ~int1'[MSB].
  - ORDER=2: int1' = sat(int1 + x - d); int2' = sat(int2 + int1' - d), using the new, saturated int1'; o_dac_out <= ~int2'[MSB].
  - o_valid <= 1.
- i_sample=0: integrators and o_dac_out hold; o_valid <= 0.
- Latency: o_dac_out and o_valid change one cycle after the i_sample edge. Back-to-back i_sample on every cycle is legal and produces one bit per cycle.
- Quantizer: value >= 0 gives 1, value < 0 gives 0.
- Overload:
  - An overload event occurs when any unsaturated sum lies outside the EW range.
  - An event sets o_overload on the next edge.
  - i_ovl_clr clears it.
  - If an event and i_ovl_clr occur in the same cycle, set wins.
  - Saturated state is retained and the loop continues; no auto-reset.
- Ones density over long runs is (x+FB)/(2·FB) for |x| < FB.

Test Plan:
- Reset: assert i_rst for 2 cycles while i_sample toggles -> o_dac_out=1, o_valid=0, o_overload=0, integrators 0. Deassert -> first sample output follows the sequences below.
- ORDER=1, DW=4, x=0, i_sample every cycle -> o_dac_out = 0,1,0,1,…; int1 = -8,0,-8,0.
- ORDER=1, x=+4, 16 samples -> repeating pattern 0,1,1,1; exactly 12 ones in 16.
- ORDER=2, x=0, i_sample every cycle -> o_dac_out = 0,0,1,1 repeating; int2 = -16,-8,8,0.
- ORDER=2, ACC_WIDTH=8, x=-8 -> int2 = -24,-32,… reaching -128 at sample 14 with o_overload still 0. Sample 15 clamps to -128 and o_overload=1 the cycle after; o_dac_out stays 0. Pulse i_ovl_clr during continued overload -> flag remains 1 (set wins). Switch to x=0 and pulse clear -> flag 0.
- i_sample gapped (1 in 4 cycles) with ORDER=2, x=0 -> same 0,0,1,1 bit sequence. Outputs hold between strobes; o_valid pulses exactly once per strobe. Assert i_rst mid-sequence -> next sample restarts at 0,0,1,1.
